// File: rtl/bin_to_bcd_stream.sv
// Multi-cycle binary-to-BCD converter (shift-add-3) with valid/ready on both sides.
// Converts BITS_PER_CYCLE operand bits per cycle and reports the sign and the significant-digit count.
module bin_to_bcd_stream #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SIGNED         = 0,
  localparam int DIGITS        = ((WIDTH * 1233) >> 12) + 1,
  localparam int NSTEP         = WIDTH / BITS_PER_CYCLE,
  localparam int NDW           = $clog2(DIGITS + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH-1:0]      bin_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  sign_o,
  output logic [NDW-1:0]        ndigits_o
);

  localparam int CW = $clog2(NSTEP + 1);

  if (WIDTH < 2 || WIDTH > 64 ||
      !(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
      (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
    $error("bin_to_bcd_stream: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      op_q, op_nxt;
  logic [4*DIGITS-1:0]   work_q, work_nxt;
  logic [CW-1:0]         cnt_q;
  logic                  neg_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  sign_q;
  logic [NDW-1:0]        nd_q, nd_nxt;
  logic                  last_step;
  logic                  neg_in;
  logic [WIDTH-1:0]      abs_in;

  // One double-dabble iteration: correct every digit that would overflow, then shift in.
  function automatic logic [4*DIGITS-1:0] dabble(input logic [4*DIGITS-1:0] w,
                                                 input logic                bit_in);
    logic [4*DIGITS-1:0] a;
    a = w;
    for (int d = 0; d < DIGITS; d++) begin
      if (a[4*d +: 4] > 4'd4) a[4*d +: 4] = a[4*d +: 4] + 4'd3;
    end
    return {a[4*DIGITS-2:0], bit_in};
  endfunction

  // Two's complement negation maps -2^(WIDTH-1) onto its unsigned magnitude in WIDTH bits.
  assign neg_in = (SIGNED != 0) && bin_i[WIDTH-1];
  assign abs_in = neg_in ? (~bin_i + WIDTH'(1)) : bin_i;

  assign last_step = (state_q == SHIFT) && (cnt_q == CW'(NSTEP - 1));

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    work_nxt = work_q;
    op_nxt   = op_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      work_nxt = dabble(work_nxt, op_nxt[WIDTH-1]);
      op_nxt   = op_nxt << 1;
    end
  end

  always_comb begin
    nd_nxt = NDW'(1);
    for (int d = 1; d < DIGITS; d++) begin
      if (work_nxt[4*d +: 4] != 4'd0) nd_nxt = NDW'(d + 1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: working registers are reset too, so an aborted conversion leaves nothing behind.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_q   <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      bcd_q  <= '0;
      sign_q <= 1'b0;
      nd_q   <= NDW'(1);
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            op_q   <= abs_in;
            neg_q  <= neg_in;
            work_q <= '0;
            cnt_q  <= '0;
          end
        end
        SHIFT: begin
          op_q   <= op_nxt;
          work_q <= work_nxt;
          cnt_q  <= cnt_q + CW'(1);
          if (last_step) begin
            bcd_q  <= work_nxt;
            sign_q <= neg_q;
            nd_q   <= nd_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd_o     = bcd_q;
  assign sign_o    = sign_q;
  assign ndigits_o = nd_q;

endmodule

// File: tb/tb_bin_to_bcd_stream.sv
// Bench for bin_to_bcd_stream: four parameter sets checked against a decimal-arithmetic model,
// with directed boundary cases, backpressure, mid-conversion reset and randomized stalls.
module tb_bin_to_bcd_stream;

  localparam int N = 4;

  // Instance configs: 0=W16/BPC1/unsigned, 1=W16/BPC1/signed, 2=W16/BPC4, 3=W32/BPC2
  int cw  [N] = '{16, 16, 16, 32};
  int csg [N] = '{0, 1, 0, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [N];
  logic        out_ready [N];
  logic        in_ready  [N];
  logic        out_valid [N];
  logic        sign      [N];
  logic [31:0] word      [N];
  logic [39:0] bcd       [N];
  logic [3:0]  nd        [N];

  logic [19:0] bcd0, bcd1, bcd2;
  logic [39:0] bcd3;
  logic [2:0]  nd0, nd1, nd2;
  logic [3:0]  nd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign bcd[0] = {20'd0, bcd0};
  assign bcd[1] = {20'd0, bcd1};
  assign bcd[2] = {20'd0, bcd2};
  assign bcd[3] = bcd3;
  assign nd[0]  = {1'b0, nd0};
  assign nd[1]  = {1'b0, nd1};
  assign nd[2]  = {1'b0, nd2};
  assign nd[3]  = nd3;

  bin_to_bcd_stream #(.WIDTH(16), .BITS_PER_CYCLE(1), .SIGNED(0)) u_dut0 (
    .clk_i(clk), .reset_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .bin_i(word[0][15:0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .bcd_o(bcd0), .sign_o(sign[0]), .ndigits_o(nd0));

  bin_to_bcd_stream #(.WIDTH(16), .BITS_PER_CYCLE(1), .SIGNED(1)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .bin_i(word[1][15:0]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .bcd_o(bcd1), .sign_o(sign[1]), .ndigits_o(nd1));

  bin_to_bcd_stream #(.WIDTH(16), .BITS_PER_CYCLE(4), .SIGNED(0)) u_dut2 (
    .clk_i(clk), .reset_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .bin_i(word[2][15:0]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
    .bcd_o(bcd2), .sign_o(sign[2]), .ndigits_o(nd2));

  bin_to_bcd_stream #(.WIDTH(32), .BITS_PER_CYCLE(2), .SIGNED(0)) u_dut3 (
    .clk_i(clk), .reset_i(rst), .in_valid_i(in_valid[3]), .in_ready_o(in_ready[3]),
    .bin_i(word[3]), .out_valid_o(out_valid[3]), .out_ready_i(out_ready[3]),
    .bcd_o(bcd3), .sign_o(sign[3]), .ndigits_o(nd3));

  // Reference: magnitude by plain arithmetic, digits by repeated division by ten.
  function automatic void model(input int k, input logic [31:0] w,
                                output logic [39:0] eb, output logic es, output logic [3:0] en);
    longint unsigned mag;
    longint unsigned wv;
    int digit;
    wv = longint'(w);
    es = 1'b0;
    if (csg[k] != 0 && w[cw[k]-1]) begin
      es  = 1'b1;
      mag = (64'd1 << cw[k]) - wv;
    end else begin
      mag = wv;
    end
    eb = '0;
    en = 4'd1;
    for (int d = 0; d < 10; d++) begin
      digit = int'(mag % 10);
      eb[4*d +: 4] = 4'(digit);
      if (digit != 0) en = 4'(d + 1);
      mag = mag / 10;
    end
  endfunction

  function automatic logic [31:0] rand_word(input int k);
    logic [31:0] r;
    r = $urandom;
    if (cw[k] == 16) r = r & 32'h0000_FFFF;
    case ($urandom % 8)
      0: r = 32'd0;
      1: r = (cw[k] == 16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      2: r = 32'd1 << (cw[k] - 1);
      3: r = $urandom % 100;
      default: ;
    endcase
    return r;
  endfunction

  // One full transaction on instance k; returns observed outputs and latency in cycles.
  task automatic convert(input int k, input logic [31:0] w, input int stall,
                         output logic [39:0] ob, output logic os, output logic [3:0] on,
                         output int lat);
    logic [39:0] eb;
    logic        es;
    logic [3:0]  en;
    int          t;
    model(k, w, eb, es, en);
    ob = '0; os = 1'b0; on = '0; lat = 0;
    @(negedge clk);
    in_valid[k] = 1'b1;
    word[k]     = w;
    t = 0;
    while (!in_ready[k] && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (in_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout k=%0d got in_ready=%b exp 1", k, in_ready[k]);
      in_valid[k] = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
    word[k]     = $urandom;
    checks++;
    if (in_ready[k] !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready k=%0d got %b exp 0", k, in_ready[k]);
    end
    lat = 1;
    while (!out_valid[k] && lat < 200) begin @(negedge clk); lat++; end
    checks++;
    if (out_valid[k] !== 1'b1) begin
      errors++;
      $display("FAIL valid_timeout k=%0d got out_valid=%b exp 1", k, out_valid[k]);
      return;
    end
    for (int i = 0; i < stall; i++) @(negedge clk);
    ob = bcd[k]; os = sign[k]; on = nd[k];
    checks++;
    if (ob !== eb || os !== es || on !== en) begin
      errors++;
      $display("FAIL result k=%0d w=%h got bcd=%h sign=%b nd=%0d exp bcd=%h sign=%b nd=%0d",
               k, w, ob, os, on, eb, es, en);
    end
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    checks++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL handshake_idle k=%0d got valid=%b ready=%b exp 0 1",
               k, out_valid[k], in_ready[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || bcd[k] !== 40'd0 ||
          sign[k] !== 1'b0 || nd[k] !== 4'd1) begin
        errors++;
        $display("FAIL reset_state k=%0d got ready=%b valid=%b bcd=%h sign=%b nd=%0d exp 1 0 0 0 1",
                 k, in_ready[k], out_valid[k], bcd[k], sign[k], nd[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [39:0] ob;
    logic        os;
    logic [3:0]  on;
    int          lat;
    convert(0, 32'hFFFF, 0, ob, os, on, lat);
    checks++;
    if (ob !== 40'h65535 || on !== 4'd5 || lat != 17) begin
      errors++;
      $display("FAIL u16_ffff got bcd=%h nd=%0d lat=%0d exp 65535 5 17", ob, on, lat);
    end
    convert(0, 32'd0, 1, ob, os, on, lat);
    checks++;
    if (ob !== 40'h0 || on !== 4'd1 || os !== 1'b0) begin
      errors++;
      $display("FAIL u16_zero got bcd=%h nd=%0d sign=%b exp 0 1 0", ob, on, os);
    end
    convert(0, 32'd9, 0, ob, os, on, lat);
    checks++;
    if (on !== 4'd1 || ob !== 40'h9) begin
      errors++;
      $display("FAIL u16_nine got bcd=%h nd=%0d exp 9 1", ob, on);
    end
    convert(0, 32'd10, 2, ob, os, on, lat);
    checks++;
    if (ob !== 40'h10 || on !== 4'd2) begin
      errors++;
      $display("FAIL u16_ten got bcd=%h nd=%0d exp 10 2", ob, on);
    end
    convert(1, 32'h8000, 0, ob, os, on, lat);
    checks++;
    if (os !== 1'b1 || ob !== 40'h32768 || on !== 4'd5) begin
      errors++;
      $display("FAIL s16_min got sign=%b bcd=%h nd=%0d exp 1 32768 5", os, ob, on);
    end
    convert(1, 32'hFFFF, 0, ob, os, on, lat);
    checks++;
    if (os !== 1'b1 || ob !== 40'h1 || on !== 4'd1) begin
      errors++;
      $display("FAIL s16_m1 got sign=%b bcd=%h nd=%0d exp 1 1 1", os, ob, on);
    end
    convert(1, 32'h7FFF, 0, ob, os, on, lat);
    checks++;
    if (os !== 1'b0 || ob !== 40'h32767) begin
      errors++;
      $display("FAIL s16_max got sign=%b bcd=%h exp 0 32767", os, ob);
    end
    convert(1, 32'h0, 0, ob, os, on, lat);
    checks++;
    if (os !== 1'b0 || ob !== 40'h0) begin
      errors++;
      $display("FAIL s16_zero got sign=%b bcd=%h exp 0 0", os, ob);
    end
    convert(2, 32'd12345, 0, ob, os, on, lat);
    checks++;
    if (ob !== 40'h12345 || lat != 5) begin
      errors++;
      $display("FAIL bpc4_12345 got bcd=%h lat=%0d exp 12345 5", ob, lat);
    end
    convert(3, 32'hFFFF_FFFF, 0, ob, os, on, lat);
    checks++;
    if (ob !== 40'h4294967295 || on !== 4'd10 || lat != 17) begin
      errors++;
      $display("FAIL w32_max got bcd=%h nd=%0d lat=%0d exp 4294967295 10 17", ob, on, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    logic [39:0] ea, eb;
    logic        sa, sb;
    logic [3:0]  na, nb;
    int          t;
    a = $urandom & 32'hFFFF;
    b = $urandom & 32'hFFFF;
    if (b == a) b = a ^ 32'h1;
    model(0, a, ea, sa, na);
    model(0, b, eb, sb, nb);
    @(negedge clk);
    in_valid[0]  = 1'b1;
    word[0]      = a;
    out_ready[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_start_ready got %b exp 1", in_ready[0]);
    end
    @(negedge clk);
    word[0] = b;
    t = 0;
    while (!out_valid[0] && t < 200) begin @(negedge clk); t++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || bcd[0] !== ea || nd[0] !== na) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got valid=%b ready=%b bcd=%h nd=%0d exp 1 0 %h %0d",
                 i, out_valid[0], in_ready[0], bcd[0], nd[0], ea, na);
      end
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle got ready=%b valid=%b exp 1 0", in_ready[0], out_valid[0]);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b0 || bcd[0] !== ea) begin
      errors++;
      $display("FAIL bp_accept_b got ready=%b bcd=%h exp 0 %h", in_ready[0], bcd[0], ea);
    end
    t = 0;
    while (!out_valid[0] && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (out_valid[0] !== 1'b1 || bcd[0] !== eb || nd[0] !== nb) begin
      errors++;
      $display("FAIL bp_result_b got valid=%b bcd=%h nd=%0d exp 1 %h %0d",
               out_valid[0], bcd[0], nd[0], eb, nb);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [39:0] ob;
    logic        os;
    logic [3:0]  on;
    int          lat;
    bit          seen;
    @(negedge clk);
    in_valid[0] = 1'b1;
    word[0]     = 32'd1234;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || bcd[0] !== 40'd0 || nd[0] !== 4'd1) begin
      errors++;
      $display("FAIL mid_reset got ready=%b valid=%b bcd=%h nd=%0d exp 1 0 0 1",
               in_ready[0], out_valid[0], bcd[0], nd[0]);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid[0]) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_abort got out_valid=1 exp 0");
    end
    convert(0, 32'd4321, 0, ob, os, on, lat);
    checks++;
    if (ob !== 40'h4321 || on !== 4'd4) begin
      errors++;
      $display("FAIL after_reset_4321 got bcd=%h nd=%0d exp 4321 4", ob, on);
    end
  endtask

  task automatic test_random(input int iters);
    logic [39:0] ob;
    logic        os;
    logic [3:0]  on;
    int          lat;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < iters; i++) begin
        convert(k, rand_word(k), int'($urandom % 4), ob, os, on, lat);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      word[k]      = '0;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_random(300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
